// File: rtl/audio_fifo_ch.sv
// rtl/audio_fifo_ch.sv - show-ahead audio sample FIFO with fill level and low-watermark flag
// Optional: define AUDIO_FIFO_LEVEL_REG_EN to register level_o / level_low_o.
module audio_fifo_ch #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 11
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WIDTH-1:0]  data_in_i,
  input  logic              push_i,
  output logic              accept_o,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [WIDTH-1:0]  data_out_o,
  input  logic              flush_i,
  input  logic [ADDR_W:0]   threshold_i,
  output logic [ADDR_W:0]   level_o,
  output logic              level_low_o,
  output logic              overflow_o,
  output logic              underrun_o
);

  localparam logic [ADDR_W:0] FULL_LVL = {1'b1, {ADDR_W{1'b0}}};

  logic [WIDTH-1:0]  mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic              fetch_q;
  logic              skid_vld;
  logic [WIDTH-1:0]  rd_data_q;
  logic [WIDTH-1:0]  skid_q;
  logic              overflow_q;
  logic              underrun_q;

  logic              push_ok;
  logic              pop_ok;
  logic              fetch;
  logic [ADDR_W:0]   ram_pending;

  assign accept_o   = (count_q != FULL_LVL);
  assign valid_o    = fetch_q | skid_vld;
  assign data_out_o = skid_vld ? skid_q : (fetch_q ? rd_data_q : '0);
  assign overflow_o = overflow_q;
  assign underrun_o = underrun_q;

  assign push_ok = push_i & accept_o & ~flush_i;
  assign pop_ok  = pop_i & valid_o & ~flush_i;

  // Words still sitting in RAM: total held minus whatever occupies the output stage.
  assign ram_pending = count_q - {{ADDR_W{1'b0}}, fetch_q} - {{ADDR_W{1'b0}}, skid_vld};
  assign fetch       = (ram_pending != '0) & (~valid_o | pop_i) & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= data_in_i;
    end
  end

  // Not reset: only observed when fetch_q is set.
  always_ff @(posedge clk_i) begin
    if (fetch) begin
      rd_data_q <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      fetch_q    <= 1'b0;
      skid_vld   <= 1'b0;
      skid_q     <= '0;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (fetch) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (ADDR_W+1)'(1);
        2'b01:   count_q <= count_q - (ADDR_W+1)'(1);
        default: count_q <= count_q;
      endcase
      fetch_q <= fetch;
      // A stalled head is parked in the skid so the RAM read data may move on.
      if (valid_o && !pop_i) begin
        skid_vld <= 1'b1;
        skid_q   <= data_out_o;
      end else begin
        skid_vld <= 1'b0;
      end
      if (push_i && !accept_o) begin
        overflow_q <= 1'b1;
      end
      if (pop_i && !valid_o) begin
        underrun_q <= 1'b1;
      end
    end
  end

`ifdef AUDIO_FIFO_LEVEL_REG_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      level_o     <= '0;
      level_low_o <= 1'b1;
    end else begin
      level_o     <= count_q;
      level_low_o <= (count_q <= threshold_i);
    end
  end
`else
  assign level_o     = count_q;
  assign level_low_o = (count_q <= threshold_i);
`endif

endmodule

// File: tb/tb_audio_fifo_ch.sv
// tb/tb_audio_fifo_ch.sv - scoreboard bench for audio_fifo_ch
module tb_audio_fifo_ch;

  localparam int DEPTH = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic        push;
  logic        pop;
  logic        flush;
  logic [31:0] din;
  logic [11:0] thr;
  logic        accept;
  logic        valid;
  logic [31:0] dout;
  logic [11:0] level;
  logic        level_low;
  logic        overflow;
  logic        underrun;

  int          total = 0;
  int          bad = 0;
  logic [31:0] sbq[$];

  always #5 clk = ~clk;

  audio_fifo_ch #(.WIDTH(32), .ADDR_W(11)) dut (
    .clk_i(clk), .rst_i(rst), .data_in_i(din), .push_i(push), .accept_o(accept),
    .pop_i(pop), .valid_o(valid), .data_out_o(dout), .flush_i(flush),
    .threshold_i(thr), .level_o(level), .level_low_o(level_low),
    .overflow_o(overflow), .underrun_o(underrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic r, input logic [31:0] d, input logic queue_it);
    push = p;
    pop  = r;
    din  = d;
    if (p && queue_it) sbq.push_back(d);
    step();
    push = 1'b0;
    pop  = 1'b0;
  endtask

  // Monitor: every consumed head word must match the oldest expected sample.
  always @(negedge clk) begin
    if (!rst && !flush && valid && pop) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected actual=%0h expected=none", dout);
      end else begin
        chk("sb_data", dout, sbq.pop_front());
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_accept"}, accept, 1);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_low"}, level_low, 1);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_unr"}, underrun, 0);
    chk({tag, "_dout"}, dout, 0);
  endtask

  initial begin
    int k;
    rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; din = '0; thr = 12'd3;
    step();
    step();
    rst = 1'b0;
    chk_reset_state("rst");

    // first-word latency
    drive(1, 0, 32'hA5A5_0001, 1);
    chk("lat_c1_valid", valid, 0);
    drive(0, 0, 0, 0);
    chk("lat_c2_valid", valid, 1);
    chk("lat_c2_data", dout, 32'hA5A5_0001);
    chk("lat_c2_level", level, 1);
    chk("lat_c2_accept", accept, 1);
    drive(0, 1, 0, 0);
    chk("lat_post_valid", valid, 0);
    chk("lat_post_level", level, 0);

    // fill to DEPTH, overflow, pop+push at full, drain
    for (int i = 0; i < DEPTH; i++) drive(1, 0, i, 1);
    chk("full_accept", accept, 0);
    chk("full_level", level, DEPTH);
    chk("full_ovf0", overflow, 0);
    drive(1, 0, 32'hDEAD_0000, 0);
    chk("ovf_set", overflow, 1);
    chk("ovf_level", level, DEPTH);
    drive(1, 1, 32'hBEEF_0000, 0);
    chk("fullpp_level", level, DEPTH - 1);
    chk("fullpp_accept", accept, 1);
    for (int i = 0; i < DEPTH - 1; i++) drive(0, 1, 0, 0);
    chk("drain_level", level, 0);
    chk("drain_valid", valid, 0);
    chk("drain_unr", underrun, 0);
    chk("ovf_sticky", overflow, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    sbq.delete();
    chk("flush_ovf", overflow, 0);
    chk("flush_level", level, 0);

    // hold the head, then burst pop
    for (int i = 0; i < 4; i++) drive(1, 0, 32'hC0DE_0000 + i, 1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", valid, 1);
      chk("hold_data", dout, 32'hC0DE_0000);
      drive(0, 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      chk("burst_valid", valid, 1);
      drive(0, 1, 0, 0);
    end
    chk("burst_end_valid", valid, 0);
    chk("burst_end_level", level, 0);

    // steady push+pop at level 10 across the pointer wrap
    k = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 32'h1000_0000 + k, 1);
      k++;
    end
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("wrap_start_level", level, 10);
    for (int c = 0; c < 2120; c++) begin
      if (c >= 2020) chk("wrap_level", level, 10);
      drive(1, 1, 32'h1000_0000 + k, 1);
      k++;
    end
    for (int i = 0; i < 10; i++) drive(0, 1, 0, 0);
    chk("wrap_drain_level", level, 0);
    chk("wrap_drain_valid", valid, 0);

    // low watermark at threshold 3, underrun
    thr = 12'd3;
    drive(1, 0, 32'h3000_0000, 1);
    drive(1, 0, 32'h3000_0001, 1);
    chk("thr_l2", level, 2);
    chk("thr_low2", level_low, 1);
    drive(1, 0, 32'h3000_0002, 1);
    chk("thr_l3", level, 3);
    chk("thr_low3", level_low, 1);
    drive(1, 0, 32'h3000_0003, 1);
    chk("thr_l4", level, 4);
    chk("thr_low4", level_low, 0);
    thr = 12'd2048;
    #1;
    chk("thr_ge_depth", level_low, 1);
    thr = 12'd3;
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0);
    chk("thr_empty_level", level, 0);
    chk("thr_unr0", underrun, 0);
    drive(0, 1, 0, 0);
    chk("unr_set", underrun, 1);
    chk("unr_level", level, 0);

    // flush beats a same-cycle push
    drive(1, 0, 32'hF000_0001, 1);
    drive(1, 0, 32'hF000_0002, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    flush = 1'b1;
    push  = 1'b1;
    din   = 32'hF000_0003;
    step();
    flush = 1'b0;
    push  = 1'b0;
    sbq.delete();
    chk("flush_level2", level, 0);
    chk("flush_valid", valid, 0);
    chk("flush_unr", underrun, 0);
    chk("flush_dout", dout, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
    chk("flush_discard_valid", valid, 0);
    chk("flush_discard_level", level, 0);

    // reset mid-operation, then resume
    drive(1, 0, 32'h5000_0001, 1);
    drive(1, 0, 32'h5000_0002, 1);
    drive(1, 1, 32'h5000_0003, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sbq.delete();
    chk_reset_state("midrst");
    drive(1, 0, 32'h6000_0001, 1);
    drive(0, 0, 0, 0);
    chk("resume_valid", valid, 1);
    chk("resume_data", dout, 32'h6000_0001);
    drive(0, 1, 0, 0);
    chk("sb_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
